// File: rtl/vth_channel_pipe.sv
// Multi-channel Vth distortion pipe: per-channel RTN (LFSR + trap) in stage 1, retention shift and saturation in stage 2.
// Optional feature: define CHANNEL_RETENTION_EN to subtract cfg_ret_shift in stage 2.
module vth_channel_pipe #(
    parameter int           VTH_W = 16,
    parameter int           NCH   = 4,
    parameter int           AMP_W = 4,
    parameter logic [15:0]  SEED  = 16'hACE1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [VTH_W-1:0]         in_vth,
    input  logic [$clog2(NCH)-1:0]   in_ch,
    input  logic [AMP_W-1:0]         cfg_rtn_amp,
    input  logic [VTH_W-1:0]         cfg_ret_shift,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [VTH_W-1:0]         out_vth,
    output logic [$clog2(NCH)-1:0]   out_ch,
    output logic [31:0]              sample_cnt
);

    localparam int          CH_W = $clog2(NCH);
    localparam logic [15:0] TAPS = 16'hB400;   // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form

    logic [15:0]             lfsr [NCH];
    logic [NCH-1:0]          trap;

    logic                    advance;
    logic                    accept;
    logic [15:0]             lfsr_cur;
    logic [15:0]             lfsr_nxt;
    logic                    trap_nxt;
    logic [VTH_W:0]          sum_nxt;

    logic                    s1_valid;
    logic [VTH_W:0]          s1_sum;
    logic [CH_W-1:0]         s1_ch;

    logic signed [VTH_W+1:0] diff;
    logic [VTH_W-1:0]        sat_vth;

    // A bubble in the output register never blocks; only a held, unaccepted output stalls.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign accept   = in_valid && advance;

    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    always_comb begin
        lfsr_cur = lfsr[in_ch];
        lfsr_nxt = {1'b0, lfsr_cur[15:1]} ^ (lfsr_cur[0] ? TAPS : 16'h0000);
        trap_nxt = trap[in_ch] ^ (lfsr_nxt[3:0] == 4'h0);
        sum_nxt  = {1'b0, in_vth};
        if (trap_nxt) begin
            sum_nxt = {1'b0, in_vth} + {{(VTH_W+1-AMP_W){1'b0}}, cfg_rtn_amp};
        end
    end

`ifdef CHANNEL_RETENTION_EN
    always_comb begin
        diff = $signed({1'b0, s1_sum}) - $signed({2'b00, cfg_ret_shift});
    end
`else
    logic unused_ret_shift;
    assign unused_ret_shift = ^cfg_ret_shift;

    always_comb begin
        diff = $signed({1'b0, s1_sum});
    end
`endif

    always_comb begin
        sat_vth = diff[VTH_W-1:0];
        if (diff[VTH_W+1]) begin
            sat_vth = '0;
        end else if (diff[VTH_W]) begin
            sat_vth = '1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments, so the stage-1 read of lfsr/trap sees pre-edge values
    // and back-to-back samples on one channel chain correctly through the comb next-state.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the channel state array is a handful of flops, not a RAM, and must be reseeded, so every entry is reset.
            for (int c = 0; c < NCH; c++) begin
                lfsr[c] <= SEED ^ 16'(c);
            end
            trap       <= '0;
            s1_valid   <= 1'b0;
            s1_sum     <= '0;
            s1_ch      <= '0;
            out_valid  <= 1'b0;
            out_vth    <= '0;
            out_ch     <= '0;
            sample_cnt <= '0;
        end else begin
            if (accept) begin
                lfsr[in_ch] <= lfsr_nxt;
                trap[in_ch] <= trap_nxt;
            end
            if (advance) begin
                s1_valid  <= in_valid;
                out_valid <= s1_valid;
                if (in_valid) begin
                    s1_sum <= sum_nxt;
                    s1_ch  <= in_ch;
                end
                if (s1_valid) begin
                    out_vth <= sat_vth;
                    out_ch  <= s1_ch;
                end
            end
            if (out_valid && out_ready) begin
                sample_cnt <= sample_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_vth_channel_pipe.sv
// Directed bench for vth_channel_pipe: reset, pass-through, saturation, backpressure, RTN reference model, mid-stream reset.
module tb_vth_channel_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_vth = '0;
    logic [1:0]  in_ch = '0;
    logic [3:0]  cfg_rtn_amp = '0;
    logic [15:0] cfg_ret_shift = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_vth;
    logic [1:0]  out_ch;
    logic [31:0] sample_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [15:0] vin;
        logic [1:0]  ch;
        logic [15:0] vexp;
    } exp_t;

    exp_t        q[$];
    logic [15:0] m_lfsr [4];
    logic [3:0]  m_trap;

    vth_channel_pipe dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_vth        (in_vth),
        .in_ch         (in_ch),
        .cfg_rtn_amp   (cfg_rtn_amp),
        .cfg_ret_shift (cfg_ret_shift),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_vth       (out_vth),
        .out_ch        (out_ch),
        .sample_cnt    (sample_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference LFSR: shift right, feedback bit toggles the positions of x^16, x^14, x^13, x^11.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic [15:0] n;
        logic        fb;
        fb    = s[0];
        n     = s >> 1;
        n[15] = n[15] ^ fb;
        n[13] = n[13] ^ fb;
        n[12] = n[12] ^ fb;
        n[10] = n[10] ^ fb;
        return n;
    endfunction

    function automatic logic [15:0] exp_sat(input int sum, input int ret);
        int d;
`ifdef CHANNEL_RETENTION_EN
        d = sum - ret;
`else
        d = sum + 0 * ret;
`endif
        if (d < 0) return 16'h0000;
        if (d > 65535) return 16'hFFFF;
        return 16'(d);
    endfunction

    task automatic model_reseed();
        for (int c = 0; c < 4; c++) m_lfsr[c] = 16'hACE1 ^ 16'(c);
        m_trap = '0;
        q.delete();
    endtask

    task automatic model_accept(input logic [15:0] vth, input logic [1:0] ch);
        logic [15:0] l;
        logic        t;
        int          sum;
        exp_t        e;
        l = lfsr_step(m_lfsr[ch]);
        t = m_trap[ch] ^ (l[3:0] == 4'h0);
        m_lfsr[ch] = l;
        m_trap[ch] = t;
        sum    = int'(vth) + (t ? int'(cfg_rtn_amp) : 0);
        e.vin  = vth;
        e.ch   = ch;
        e.vexp = exp_sat(sum, int'(cfg_ret_shift));
        q.push_back(e);
    endtask

    // Drive one cycle's inputs just after the rising edge, return at the falling edge.
    task automatic tick(input logic v, input logic [15:0] vth, input logic [1:0] ch, input logic rdy,
                        output logic acc);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_vth    = vth;
        in_ch     = ch;
        out_ready = rdy;
        @(negedge clk);
        acc = in_valid && in_ready;
        if (acc) model_accept(vth, ch);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        reset    = 1'b1;
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reseed();
        @(negedge clk);
    endtask

    // Push one sample and wait (bounded) for its output; ok=0 if it never appears.
    task automatic single(input logic [15:0] vth, input logic [1:0] ch, output logic [15:0] obs, output logic ok);
        logic acc;
        ok  = 1'b0;
        obs = '0;
        tick(1'b1, vth, ch, 1'b1, acc);
        for (int i = 0; i < 6 && !ok; i++) begin
            tick(1'b0, 16'h0, 2'd0, 1'b1, acc);
            if (out_valid) begin
                ok  = 1'b1;
                obs = out_vth;
                if (q.size() > 0) void'(q.pop_front());
            end
        end
    endtask

    task automatic test_reset();
        do_reset(3);
        n_cmp += 5;
        if (out_valid !== 1'b0)   begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        if (out_vth !== 16'h0)    begin n_bad++; $display("FAIL reset_out_vth: got %h want 0000", out_vth); end
        if (out_ch !== 2'd0)      begin n_bad++; $display("FAIL reset_out_ch: got %0d want 0", out_ch); end
        if (sample_cnt !== 32'd0) begin n_bad++; $display("FAIL reset_sample_cnt: got %0d want 0", sample_cnt); end
        if (in_ready !== 1'b1)    begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_passthrough();
        logic acc;
        cfg_rtn_amp   = 4'd0;
        cfg_ret_shift = 16'h0;
        tick(1'b1, 16'h1234, 2'd2, 1'b1, acc);
        n_cmp++;
        if (acc !== 1'b1) begin n_bad++; $display("FAIL pass_accept: got %b want 1", acc); end
        tick(1'b0, 16'h0, 2'd0, 1'b1, acc);
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL pass_early_valid: got %b want 0", out_valid); end
        tick(1'b0, 16'h0, 2'd0, 1'b1, acc);
        n_cmp += 3;
        if (out_valid !== 1'b1)   begin n_bad++; $display("FAIL pass_valid: got %b want 1", out_valid); end
        if (out_vth !== 16'h1234) begin n_bad++; $display("FAIL pass_vth: got %h want 1234", out_vth); end
        if (out_ch !== 2'd2)      begin n_bad++; $display("FAIL pass_ch: got %0d want 2", out_ch); end
        if (q.size() > 0) void'(q.pop_front());
        tick(1'b0, 16'h0, 2'd0, 1'b1, acc);
        n_cmp += 2;
        if (sample_cnt !== 32'd1) begin n_bad++; $display("FAIL pass_count: got %0d want 1", sample_cnt); end
        if (out_valid !== 1'b0)   begin n_bad++; $display("FAIL pass_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_saturation();
        logic [15:0] obs;
        logic        ok;
        cfg_rtn_amp   = 4'd15;
        cfg_ret_shift = 16'h0;
        for (int i = 0; i < 4; i++) begin
            single(16'hFFFF, 2'(i), obs, ok);
            n_cmp++;
            if (!ok || obs !== 16'hFFFF) begin
                n_bad++; $display("FAIL sat_high ch%0d: got %h ok=%b want ffff", i, obs, ok);
            end
        end
        cfg_rtn_amp   = 4'd0;
        cfg_ret_shift = 16'h0100;
        single(16'h0010, 2'd3, obs, ok);
        n_cmp++;
`ifdef CHANNEL_RETENTION_EN
        if (!ok || obs !== 16'h0000) begin n_bad++; $display("FAIL sat_low: got %h ok=%b want 0000", obs, ok); end
`else
        if (!ok || obs !== 16'h0010) begin n_bad++; $display("FAIL ret_ignored: got %h ok=%b want 0010", obs, ok); end
`endif
        cfg_ret_shift = 16'h0;
    endtask

    task automatic test_backpressure();
        logic        acc;
        logic        rdy;
        logic        prev_stall;
        logic [15:0] prev_vth;
        int          sent;
        int          got;
        exp_t        e;
        do_reset(2);
        cfg_rtn_amp = 4'd3;
        sent = 0;
        got  = 0;
        prev_stall = 1'b0;
        prev_vth   = '0;
        for (int cyc = 0; cyc < 30 && got < 6; cyc++) begin
            rdy = !(cyc >= 3 && cyc <= 7);
            tick(sent < 6, 16'h1000 + 16'(sent) * 16'h0111, 2'(sent % 4), rdy, acc);
            if (acc) sent++;
            if (out_valid && !rdy) begin
                n_cmp++;
                if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready cyc%0d: got %b want 0", cyc, in_ready); end
                if (prev_stall) begin
                    n_cmp++;
                    if (out_vth !== prev_vth) begin n_bad++; $display("FAIL bp_hold cyc%0d: got %h want %h", cyc, out_vth, prev_vth); end
                end
            end
            prev_stall = out_valid && !rdy;
            prev_vth   = out_vth;
            if (out_valid && rdy) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++; $display("FAIL bp_extra: unexpected output %h", out_vth);
                end else begin
                    e = q.pop_front();
                    got++;
                    if (out_vth !== e.vexp || out_ch !== e.ch) begin
                        n_bad++; $display("FAIL bp_data #%0d: got %h/ch%0d want %h/ch%0d", got, out_vth, out_ch, e.vexp, e.ch);
                    end
                end
            end
        end
        tick(1'b0, 16'h0, 2'd0, 1'b1, acc);
        n_cmp += 3;
        if (got != 6)              begin n_bad++; $display("FAIL bp_delivered: got %0d want 6", got); end
        if (sample_cnt !== 32'd6)  begin n_bad++; $display("FAIL bp_count: got %0d want 6", sample_cnt); end
        if (out_valid !== 1'b0)    begin n_bad++; $display("FAIL bp_dup: out_valid %b want 0", out_valid); end
    endtask

    task automatic test_rtn_model();
        logic        acc;
        logic        v;
        logic        rdy;
        logic [63:0] seq0;
        logic [63:0] seq1;
        int          n0;
        int          n1;
        int          sent;
        int          got;
        int          bad_before;
        exp_t        e;
        do_reset(2);
        cfg_rtn_amp = 4'd7;
        sent = 0;
        got  = 0;
        n0   = 0;
        n1   = 0;
        seq0 = '0;
        seq1 = '0;
        bad_before = n_bad;
        for (int cyc = 0; cyc < 6000 && got < 1000; cyc++) begin
            v   = (sent < 1000) && ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            tick(v, 16'($urandom_range(0, 16'hFF00)), 2'($urandom_range(0, 3)), rdy, acc);
            if (acc) sent++;
            if (out_valid && rdy) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++; $display("FAIL rtn_extra: unexpected output %h", out_vth);
                end else begin
                    e = q.pop_front();
                    got++;
                    if (out_vth !== e.vexp || out_ch !== e.ch) begin
                        if (n_bad - bad_before < 10)
                            $display("FAIL rtn_data #%0d: got %h/ch%0d want %h/ch%0d", got, out_vth, out_ch, e.vexp, e.ch);
                        n_bad++;
                    end
                    if (e.ch == 2'd0 && n0 < 64) begin seq0[n0] = (out_vth != e.vin); n0++; end
                    if (e.ch == 2'd1 && n1 < 64) begin seq1[n1] = (out_vth != e.vin); n1++; end
                end
            end
        end
        n_cmp += 2;
        if (got != 1000) begin n_bad++; $display("FAIL rtn_delivered: got %0d want 1000", got); end
        if (n0 < 64 || n1 < 64 || seq0 === seq1) begin
            n_bad++; $display("FAIL rtn_ch_differ: ch0 %h (%0d) ch1 %h (%0d) want distinct", seq0, n0, seq1, n1);
        end
    endtask

    task automatic test_reset_midstream();
        logic        acc;
        logic [15:0] obs;
        logic        ok;
        cfg_rtn_amp   = 4'd7;
        cfg_ret_shift = 16'h0;
        for (int i = 0; i < 3; i++) single(16'h0200, 2'd0, obs, ok);
        tick(1'b1, 16'h0500, 2'd0, 1'b0, acc);
        tick(1'b1, 16'h0600, 2'd1, 1'b0, acc);
        tick(1'b0, 16'h0, 2'd0, 1'b0, acc);
        n_cmp += 2;
        if (out_valid !== 1'b1) begin n_bad++; $display("FAIL mid_inflight: out_valid %b want 1", out_valid); end
        if (in_ready !== 1'b0)  begin n_bad++; $display("FAIL mid_full: in_ready %b want 0", in_ready); end
        do_reset(1);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 16'h0, 2'd0, 1'b1, acc);
            n_cmp += 2;
            if (out_valid !== 1'b0)   begin n_bad++; $display("FAIL mid_flushed %0d: out_valid %b want 0", i, out_valid); end
            if (sample_cnt !== 32'd0) begin n_bad++; $display("FAIL mid_count %0d: got %0d want 0", i, sample_cnt); end
        end
        // Fresh ch-0 LFSR: ACE1 -> E270, low nibble zero, so the trap fills and amp 7 is added.
        single(16'h0100, 2'd0, obs, ok);
        n_cmp++;
        if (!ok || obs !== 16'h0107) begin n_bad++; $display("FAIL mid_reseed: got %h ok=%b want 0107", obs, ok); end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_saturation();
        test_backpressure();
        test_rtn_model();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
